// File: rtl/lane_serializer_pkg.sv
// Shared types and defaults for the lane serializer.
// Holds the FSM state encoding, the default lane index type and the default geometry.
// Imported by the interface, the lane selector and the top.
package lane_ser_pkg;

  localparam int LANES_DEF = 8;
  localparam int WIDTH_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef logic [$clog2(LANES_DEF)-1:0] idx_t;

endpackage

// File: rtl/lane_serializer_if.sv
// Bundles both streams of the lane serializer: the wide vector input and the narrow beat output.
// slave modport = the serializer (consumes in_*, produces out_*); master modport = its environment.
// Ports: in_valid/in_ready/in_data/in_mask, out_valid/out_ready/out_data/out_index/out_last.
interface lane_serializer_if #(
  parameter int LANES = 8,
  parameter int WIDTH = 32
);
  localparam int IW = $clog2(LANES);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES-1:0]       in_mask;

  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [IW-1:0]          out_index;
  logic                   out_last;

  modport slave (
    input  in_valid, in_data, in_mask, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );

  modport master (
    output in_valid, in_data, in_mask, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

endinterface

// File: rtl/lane_serializer_next_sel.sv
// Combinational lane picker: lowest enabled lane of a mask, optionally after clearing the current lane.
// Zero latency. No backpressure of its own.
// Ports: mask/curIdx/clrCur in; remMask (mask after clear), lowIdx, anySet, isLast out.
module lane_next_sel #(
  parameter int LANES = 8,
  localparam int IW = $clog2(LANES)
) (
  input  logic [LANES-1:0] mask,
  input  logic [IW-1:0]    curIdx,
  input  logic             clrCur,
  output logic [LANES-1:0] remMask,
  output logic [IW-1:0]    lowIdx,
  output logic             anySet,
  output logic             isLast
);

  always_comb begin
    remMask = mask;
    if (clrCur) begin
      remMask[curIdx] = 1'b0;
    end
    lowIdx = '0;
    anySet = 1'b0;
    // Scan downwards so the last hit wins, leaving the lowest set lane.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (remMask[i]) begin
        lowIdx = IW'(i);
        anySet = 1'b1;
      end
    end
    // At most one bit left means the lowest lane is also the highest: last beat.
    isLast = ((remMask & (remMask - LANES'(1))) == '0);
  end

endmodule

// File: rtl/lane_serializer.sv
// Serializes a LANES-wide vector into one word per beat, skipping masked-off lanes with no bubbles.
// Latency: first beat 1 cycle after accept; back-to-back vectors sustain 1 beat/cycle.
// Backpressure: outputs hold while out_ready=0; in_ready only in IDLE or on the accepted last beat.
// Ports: clk, rst (async, active-high), bus (slave modport), drop_count (saturating all-zero-mask count).
module lane_serializer
  import lane_ser_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  lane_serializer_if.slave  bus,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int IW = $clog2(LANES);

  state_t                 state, stateNext;
  logic [LANES*WIDTH-1:0] dataQ;
  logic [LANES-1:0]       maskQ;
  logic [WIDTH-1:0]       outData;
  logic [IW-1:0]          outIndex;
  logic                   outLast;
  logic                   outValid;

  logic                   sendBeat, advance, sendLast, inReady, accept;
  logic                   loadVec, dropInc;
  logic [LANES-1:0]       selMask, remMask;
  logic [IW-1:0]          lowIdx;
  logic                   anySet, isLast;

  assign outValid = (state == SEND);
  assign sendBeat = outValid && bus.out_ready;
  assign advance  = sendBeat && !outLast;
  assign sendLast = sendBeat && outLast;
  // Combinational from out_ready so a new vector can load on the last beat.
  assign inReady  = (state == IDLE) || sendLast;
  assign accept   = bus.in_valid && inReady;

  // One selector serves both jobs: advancing inside the held vector, or
  // picking the first lane of the incoming one. advance and accept never overlap.
  assign selMask = advance ? maskQ : bus.in_mask;

  lane_next_sel #(.LANES(LANES)) nextSel (
    .mask   (selMask),
    .curIdx (outIndex),
    .clrCur (advance),
    .remMask(remMask),
    .lowIdx (lowIdx),
    .anySet (anySet),
    .isLast (isLast)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    loadVec   = 1'b0;
    dropInc   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (anySet) begin
            loadVec   = 1'b1;
            stateNext = SEND;
          end else begin
            dropInc = 1'b1;
          end
        end
      end
      SEND: begin
        if (sendLast) begin
          if (accept && anySet) begin
            loadVec = 1'b1;
          end else begin
            stateNext = IDLE;
            dropInc   = accept;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataQ      <= '0;
      maskQ      <= '0;
      outData    <= '0;
      outIndex   <= '0;
      outLast    <= 1'b0;
      drop_count <= '0;
    end else begin
      if (accept) begin
        dataQ <= bus.in_data;
        maskQ <= bus.in_mask;
      end
      if (loadVec) begin
        outIndex <= lowIdx;
        outData  <= bus.in_data[int'(lowIdx) * WIDTH +: WIDTH];
        outLast  <= isLast;
      end else if (advance) begin
        maskQ    <= remMask;
        outIndex <= lowIdx;
        outData  <= dataQ[int'(lowIdx) * WIDTH +: WIDTH];
        outLast  <= isLast;
      end
      if (dropInc && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_data  = outData;
  assign bus.out_index = outIndex;
  assign bus.out_last  = outLast;

  stallHold: assert property (@(posedge clk) disable iff (rst)
    (outValid && !bus.out_ready) |=>
      (outValid && $stable(outData) && $stable(outIndex) && $stable(outLast)));

  laneEnabled: assert property (@(posedge clk) disable iff (rst)
    outValid |-> maskQ[outIndex]);

endmodule
